datapath_control_fsm: RTL and testbench
=======================================

// Module: datapath_control_fsm
// PURPOSE
//  Multi-cycle RV32I control FSM that sequences Data_path: fetch, decode, execute, memory, writeback.
//  Drives every Data_path control input and takes opcode/funct3 from the instruction register output.
//  Handles variable RAM latency through a ready handshake.
//  Counts retired instructions and halts on ECALL/EBREAK or on an illegal encoding.
// PARAMETERS
//  CWIDTH      32   width of retireCount
//  MEM_TIMEOUT 15   max cycles in MEM waiting for ramReady before trapping (4-bit counter)
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  reset        in   1      synchronous, active-low; sampled on rising clk
//  run          in   1      1 = advance FSM; 0 = hold in FETCH (only FETCH checks it)
//  opcode       in   7      irOut[6:0]
//  funct3       in   3      irOut[14:12]
//  ramReady     in   1      RAM access complete (read data valid / write done)
//  pcEn         out  1      PC update strobe, 1 cycle per retired instruction
//  pcSelect     out  2      00 PC+4, 01 branch/JAL (PC+imm, comparator-gated), 10 JALR (ALU)
//  regWrite     out  1      register-file write strobe
//  aluSrc       out  1      0 rs2, 1 immediate
//  ramRdEn      out  1      RAM read enable
//  ramWrEn      out  1      RAM write enable
//  isByte       out  1      byte access
//  isHalf       out  1      halfword access
//  isWord       out  1      word access
//  memToReg     out  2      00 ALU, 01 RAM, 10 PC link, 11 imm
//  halted       out  1      sticky; 1 after ECALL/EBREAK
//  illegal      out  1      sticky; 1 after bad opcode/funct3 or MEM timeout
//  retireCount  out  CWIDTH instructions retired, wraps modulo 2^CWIDTH
// BEHAVIOUR
//  Reset (reset==0 at edge): state=FETCH. All outputs 0, including halted, illegal and retireCount.
//  Reset has priority mid-instruction and abandons any RAM access with no pcEn.
//  States:
//   FETCH  - if run, go to DECODE (IR is registered, 1-cycle fetch).
//   DECODE - latch opcode/funct3 into internal registers.
//            Legal set: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011,
//            JAL 1101111, JALR 1100111, LUI 0110111, SYSTEM 1110011.
//            SYSTEM goes to HALT; anything else illegal goes to TRAP; otherwise EXEC.
//   EXEC   - aluSrc=1 for I/LOAD/STORE/JALR, else 0.
//            LOAD/STORE go to MEM. BRANCH goes to WB with no regWrite. Others go to WB.
//   MEM    - ramRdEn (LOAD) or ramWrEn (STORE) held high until ramReady is sampled 1.
//            Width: funct3[1:0] 00 isByte, 01 isHalf, 10 isWord. Width strobes are one-hot and held for all of MEM.
//            LOAD funct3 of 011, 110 or 111, or STORE funct3 >= 011, goes to TRAP from DECODE (no RAM access).
//            If ramReady is 1 on the first MEM cycle, the access takes 1 cycle.
//            After MEM_TIMEOUT cycles without ramReady, drop the enables and go to TRAP.
//   WB     - one cycle with pcEn=1 and retireCount += 1.
//            regWrite=1 for R, I, LOAD, JAL, JALR, LUI. memToReg: LOAD 01, JAL/JALR 10, LUI 11, else 00.
//            pcSelect: BRANCH/JAL 01, JALR 10, else 00. Next state FETCH.
//   HALT   - set halted; no strobes; stay until reset.
//   TRAP   - set illegal; no strobes; stay until reset.
//  All strobes are Moore outputs, registered from state and latched decode. No combinational path from ramReady.
//  pcEn, regWrite and ramWrEn are never 1 in the same cycle as one another except pcEn+regWrite in WB.
//  Latency: ALU and branch ops take 4 cycles; LOAD/STORE take 5 + wait cycles.
//  run=0 never interrupts an instruction in progress.
// STRUCTURE
//  Shared package (riscv_pkg) holds the opcode localparams, state encoding, and the pcSelect and memToReg encodings.
//  These are also used by the alu_controller and comparator decode.
//  Sub-module control_decode: combinational, opcode/funct3 -> {legal, isSystem, isMem, aluSrc, regWrite, memToReg, pcSelect, width}.
//  The FSM, timeout counter and retire counter stay in the top module.
// TESTING
//  ADD (0110011): 4 cycles; pcEn and regWrite high together in cycle 4, memToReg=00, retireCount 0->1.
//  LW (0000011, f3=010), ramReady low for 3 cycles: ramRdEn+isWord high for 4 MEM cycles, then WB with memToReg=01; 8 cycles total.
//  SB (0100011, f3=000), ramReady=1: 1 MEM cycle with ramWrEn+isByte; WB with pcEn=1 and regWrite=0.
//  Opcode 0010111 -> illegal=1 after DECODE, no pcEn ever. LW with ramReady stuck 0 -> TRAP after 15 MEM cycles.
//  ECALL -> halted=1; hold 20 cycles with all strobes 0. Then reset=0 for 1 cycle -> all outputs 0, FETCH.
//  Assert reset=0 during MEM of a load -> next cycle ramRdEn=0, state FETCH, retireCount=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I control encodings: opcodes, sequencer states, PC/writeback
// select codes, access widths and the decoded control bundle.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        PCS_PLUS4  = 2'b00,
        PCS_BRANCH = 2'b01,
        PCS_JALR   = 2'b10
    } pc_sel_t;

    typedef enum logic [1:0] {
        MTR_ALU  = 2'b00,
        MTR_RAM  = 2'b01,
        MTR_LINK = 2'b10,
        MTR_IMM  = 2'b11
    } mem_to_reg_t;

    // Encoding matches funct3[1:0] of loads and stores
    typedef enum logic [1:0] {
        W_BYTE = 2'b00,
        W_HALF = 2'b01,
        W_WORD = 2'b10,
        W_NONE = 2'b11
    } width_t;

    typedef struct packed {
        logic        legal;
        logic        is_system;
        logic        is_mem;
        logic        is_load;
        logic        alu_src;
        logic        reg_write;
        mem_to_reg_t mem_to_reg;
        pc_sel_t     pc_select;
        width_t      width;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decode: opcode/funct3 to the control bundle
// that the sequencer registers onto the datapath strobes.
module control_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output ctrl_t      ctrl
);

    // Map each legal opcode to its datapath controls; unknown encodings stay illegal
    always_comb begin
        ctrl            = '0;
        ctrl.mem_to_reg = MTR_ALU;
        ctrl.pc_select  = PCS_PLUS4;
        ctrl.width      = width_t'(funct3[1:0]);
        case (opcode)
            OP_R: begin
                ctrl.legal     = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_I: begin
                ctrl.legal     = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_LOAD: begin
                // LB/LH/LW/LBU/LHU only; 011, 110, 111 have no RV32I load
                ctrl.legal      = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                ctrl.is_mem     = 1'b1;
                ctrl.is_load    = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = MTR_RAM;
            end
            OP_STORE: begin
                ctrl.legal   = (funct3 < 3'b011);
                ctrl.is_mem  = 1'b1;
                ctrl.alu_src = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.legal     = 1'b1;
                ctrl.pc_select = PCS_BRANCH;
            end
            OP_JAL: begin
                ctrl.legal      = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = MTR_LINK;
                ctrl.pc_select  = PCS_BRANCH;
            end
            OP_JALR: begin
                ctrl.legal      = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = MTR_LINK;
                ctrl.pc_select  = PCS_JALR;
            end
            OP_LUI: begin
                ctrl.legal      = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = MTR_IMM;
            end
            OP_SYSTEM: begin
                ctrl.legal     = 1'b1;
                ctrl.is_system = 1'b1;
            end
            default: ctrl.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/datapath_control_fsm.sv
// Multi-cycle RV32I sequencer: FETCH, DECODE, EXEC, optional MEM with a
// ready handshake and timeout, WB. All strobes are registered Moore outputs
// computed for the state being entered.
module datapath_control_fsm
    import riscv_pkg::*;
#(
    parameter int CWIDTH      = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              ramReady,
    output logic              pcEn,
    output logic [1:0]        pcSelect,
    output logic              regWrite,
    output logic              aluSrc,
    output logic              ramRdEn,
    output logic              ramWrEn,
    output logic              isByte,
    output logic              isHalf,
    output logic              isWord,
    output logic [1:0]        memToReg,
    output logic              halted,
    output logic              illegal,
    output logic [CWIDTH-1:0] retireCount
);

    // Last MEM cycle index (counter starts at 0 on the first MEM cycle)
    localparam logic [3:0] MEM_LAST = 4'(MEM_TIMEOUT - 1);

    state_t     state;
    logic [6:0] op_q;
    logic [2:0] f3_q;
    logic [3:0] mem_cnt;
    logic [6:0] dec_opcode;
    logic [2:0] dec_funct3;
    ctrl_t      ctrl;

    // Decode the live IR while in DECODE so the EXEC strobes can be registered
    // on the same edge; afterwards the latched copy keeps decode stable
    assign dec_opcode = (state == S_DECODE) ? opcode : op_q;
    assign dec_funct3 = (state == S_DECODE) ? funct3 : f3_q;

    control_decode u_decode (
        .opcode (dec_opcode),
        .funct3 (dec_funct3),
        .ctrl   (ctrl)
    );

    // Sequencer: next state, latched instruction fields, strobes and counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_FETCH;
            op_q        <= '0;
            f3_q        <= '0;
            mem_cnt     <= '0;
            pcEn        <= 1'b0;
            pcSelect    <= PCS_PLUS4;
            regWrite    <= 1'b0;
            aluSrc      <= 1'b0;
            ramRdEn     <= 1'b0;
            ramWrEn     <= 1'b0;
            isByte      <= 1'b0;
            isHalf      <= 1'b0;
            isWord      <= 1'b0;
            memToReg    <= MTR_ALU;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            retireCount <= '0;
        end else begin
            // Strobes drop unless the state being entered raises them
            pcEn     <= 1'b0;
            pcSelect <= PCS_PLUS4;
            regWrite <= 1'b0;
            aluSrc   <= 1'b0;
            ramRdEn  <= 1'b0;
            ramWrEn  <= 1'b0;
            isByte   <= 1'b0;
            isHalf   <= 1'b0;
            isWord   <= 1'b0;
            memToReg <= MTR_ALU;

            case (state)
                S_FETCH: begin
                    if (run) state <= S_DECODE;
                end

                S_DECODE: begin
                    op_q <= opcode;
                    f3_q <= funct3;
                    if (!ctrl.legal) begin
                        state   <= S_TRAP;
                        illegal <= 1'b1;
                    end else if (ctrl.is_system) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state  <= S_EXEC;
                        aluSrc <= ctrl.alu_src;
                    end
                end

                S_EXEC: begin
                    // Operand select stays applied through MEM/WB: address and JALR target come from the ALU
                    aluSrc <= ctrl.alu_src;
                    if (ctrl.is_mem) begin
                        state   <= S_MEM;
                        mem_cnt <= '0;
                        ramRdEn <= ctrl.is_load;
                        ramWrEn <= !ctrl.is_load;
                        isByte  <= (ctrl.width == W_BYTE);
                        isHalf  <= (ctrl.width == W_HALF);
                        isWord  <= (ctrl.width == W_WORD);
                    end else begin
                        state    <= S_WB;
                        pcEn     <= 1'b1;
                        regWrite <= ctrl.reg_write;
                        memToReg <= ctrl.mem_to_reg;
                        pcSelect <= ctrl.pc_select;
                    end
                end

                S_MEM: begin
                    if (ramReady) begin
                        state    <= S_WB;
                        aluSrc   <= ctrl.alu_src;
                        pcEn     <= 1'b1;
                        regWrite <= ctrl.reg_write;
                        memToReg <= ctrl.mem_to_reg;
                        pcSelect <= ctrl.pc_select;
                    end else if (mem_cnt == MEM_LAST) begin
                        // RAM never answered: abandon the access
                        state   <= S_TRAP;
                        illegal <= 1'b1;
                    end else begin
                        mem_cnt <= mem_cnt + 4'd1;
                        aluSrc  <= aluSrc;
                        ramRdEn <= ramRdEn;
                        ramWrEn <= ramWrEn;
                        isByte  <= isByte;
                        isHalf  <= isHalf;
                        isWord  <= isWord;
                    end
                end

                S_WB: begin
                    state       <= S_FETCH;
                    retireCount <= retireCount + CWIDTH'(1);
                end

                S_HALT: state <= S_HALT;

                S_TRAP: state <= S_TRAP;

                default: state <= S_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_control_fsm.sv
// Scoreboard bench for datapath_control_fsm: the stimulus process queues the
// hand-computed output vector for each cycle it drives, and a monitor pops
// and compares one entry on every falling edge.
module tb_datapath_control_fsm;

    typedef struct packed {
        logic        pcEn;
        logic [1:0]  pcSelect;
        logic        regWrite;
        logic        aluSrc;
        logic        ramRdEn;
        logic        ramWrEn;
        logic        isByte;
        logic        isHalf;
        logic        isWord;
        logic [1:0]  memToReg;
        logic        halted;
        logic        illegal;
        logic [31:0] retireCount;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
    } exp_item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        ramReady;
    logic        pcEn;
    logic [1:0]  pcSelect;
    logic        regWrite;
    logic        aluSrc;
    logic        ramRdEn;
    logic        ramWrEn;
    logic        isByte;
    logic        isHalf;
    logic        isWord;
    logic [1:0]  memToReg;
    logic        halted;
    logic        illegal;
    logic [31:0] retireCount;

    exp_item_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    datapath_control_fsm #(.CWIDTH(32), .MEM_TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .opcode      (opcode),
        .funct3      (funct3),
        .ramReady    (ramReady),
        .pcEn        (pcEn),
        .pcSelect    (pcSelect),
        .regWrite    (regWrite),
        .aluSrc      (aluSrc),
        .ramRdEn     (ramRdEn),
        .ramWrEn     (ramWrEn),
        .isByte      (isByte),
        .isHalf      (isHalf),
        .isWord      (isWord),
        .memToReg    (memToReg),
        .halted      (halted),
        .illegal     (illegal),
        .retireCount (retireCount)
    );

    // Expected-vector builders; all arguments are written out by hand at the call sites
    function automatic obs_t ob_idle(input int unsigned rc);
        obs_t o = '0;
        o.retireCount = rc;
        return o;
    endfunction

    function automatic obs_t ob_exe(input bit as, input int unsigned rc);
        obs_t o = '0;
        o.aluSrc      = as;
        o.retireCount = rc;
        return o;
    endfunction

    function automatic obs_t ob_mem(input bit rd, input bit wr, input bit b, input bit h,
                                    input bit w, input int unsigned rc);
        obs_t o = '0;
        o.aluSrc      = 1'b1;
        o.ramRdEn     = rd;
        o.ramWrEn     = wr;
        o.isByte      = b;
        o.isHalf      = h;
        o.isWord      = w;
        o.retireCount = rc;
        return o;
    endfunction

    function automatic obs_t ob_wb(input logic [1:0] ps, input bit rw, input bit as,
                                   input logic [1:0] mt, input int unsigned rc);
        obs_t o = '0;
        o.pcEn        = 1'b1;
        o.pcSelect    = ps;
        o.regWrite    = rw;
        o.aluSrc      = as;
        o.memToReg    = mt;
        o.retireCount = rc;
        return o;
    endfunction

    function automatic obs_t ob_stop(input bit hl, input bit il, input int unsigned rc);
        obs_t o = '0;
        o.halted      = hl;
        o.illegal     = il;
        o.retireCount = rc;
        return o;
    endfunction

    // Advance one clock and queue the outputs required for the cycle just entered
    task automatic cyc(input string tag, input obs_t e);
        exp_item_t it;
        @(posedge clk);
        #1;
        it.tag = tag;
        it.v   = e;
        sb_q.push_back(it);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3);
        opcode = op;
        funct3 = f3;
    endtask

    // Reset pulse: one cycle low, then release with run held low so FETCH idles
    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        cyc(tag, ob_idle(0));
        reset = 1'b1;
        run   = 1'b0;
        cyc({tag, "_idle"}, ob_idle(0));
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation
    initial begin
        exp_item_t e;
        obs_t      got;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn,
                       isByte, isHalf, isWord, memToReg, halted, illegal, retireCount};
                n_checks++;
                if (got !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h (pcEn..illegal,retireCount)",
                             e.tag, got, e.v);
                end
            end
        end
    end

    // Stimulus
    initial begin
        reset    = 1'b0;
        run      = 1'b0;
        opcode   = 7'b0;
        funct3   = 3'b0;
        ramReady = 1'b0;

        cyc("reset", ob_idle(0));
        reset = 1'b1;
        cyc("idle_run0", ob_idle(0));
        cyc("idle_run0_b", ob_idle(0));

        // ADD: 4 cycles, WB has pcEn+regWrite, memToReg 00
        run = 1'b1;
        set_instr(7'b0110011, 3'b000);
        cyc("add_dec", ob_idle(0));
        cyc("add_exe", ob_exe(1'b0, 0));
        cyc("add_wb", ob_wb(2'b00, 1'b1, 1'b0, 2'b00, 0));
        cyc("add_fetch", ob_idle(1));

        // LW with ramReady low for 3 MEM cycles: 4 MEM cycles, 8 total
        set_instr(7'b0000011, 3'b010);
        ramReady = 1'b0;
        cyc("lw_dec", ob_idle(1));
        cyc("lw_exe", ob_exe(1'b1, 1));
        cyc("lw_mem0", ob_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1));
        cyc("lw_mem1", ob_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1));
        cyc("lw_mem2", ob_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1));
        cyc("lw_mem3", ob_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1));
        ramReady = 1'b1;
        cyc("lw_wb", ob_wb(2'b00, 1'b1, 1'b1, 2'b01, 1));
        ramReady = 1'b0;
        cyc("lw_fetch", ob_idle(2));

        // SB with immediate ready: one MEM cycle, WB without regWrite
        set_instr(7'b0100011, 3'b000);
        ramReady = 1'b1;
        cyc("sb_dec", ob_idle(2));
        cyc("sb_exe", ob_exe(1'b1, 2));
        cyc("sb_mem", ob_mem(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2));
        cyc("sb_wb", ob_wb(2'b00, 1'b0, 1'b1, 2'b00, 2));
        cyc("sb_fetch", ob_idle(3));

        // LHU with immediate ready: halfword read
        set_instr(7'b0000011, 3'b101);
        cyc("lhu_dec", ob_idle(3));
        cyc("lhu_exe", ob_exe(1'b1, 3));
        cyc("lhu_mem", ob_mem(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3));
        cyc("lhu_wb", ob_wb(2'b00, 1'b1, 1'b1, 2'b01, 3));
        ramReady = 1'b0;
        cyc("lhu_fetch", ob_idle(4));

        // JAL: link writeback, PC+imm
        set_instr(7'b1101111, 3'b000);
        cyc("jal_dec", ob_idle(4));
        cyc("jal_exe", ob_exe(1'b0, 4));
        cyc("jal_wb", ob_wb(2'b01, 1'b1, 1'b0, 2'b10, 4));
        cyc("jal_fetch", ob_idle(5));

        // BEQ: no register write, branch PC select
        set_instr(7'b1100011, 3'b000);
        cyc("beq_dec", ob_idle(5));
        cyc("beq_exe", ob_exe(1'b0, 5));
        cyc("beq_wb", ob_wb(2'b01, 1'b0, 1'b0, 2'b00, 5));
        cyc("beq_fetch", ob_idle(6));

        // JALR: immediate operand, ALU target, link writeback
        set_instr(7'b1100111, 3'b000);
        cyc("jalr_dec", ob_idle(6));
        cyc("jalr_exe", ob_exe(1'b1, 6));
        cyc("jalr_wb", ob_wb(2'b10, 1'b1, 1'b1, 2'b10, 6));
        cyc("jalr_fetch", ob_idle(7));

        // LUI with run dropped after DECODE: instruction still completes, then FETCH holds
        set_instr(7'b0110111, 3'b000);
        cyc("lui_dec", ob_idle(7));
        run = 1'b0;
        cyc("lui_exe", ob_exe(1'b0, 7));
        cyc("lui_wb", ob_wb(2'b00, 1'b1, 1'b0, 2'b11, 7));
        cyc("lui_fetch", ob_idle(8));
        cyc("lui_hold", ob_idle(8));

        // Reset during MEM of a load abandons the access and clears the count
        run = 1'b1;
        set_instr(7'b0000011, 3'b010);
        ramReady = 1'b0;
        cyc("rstmem_dec", ob_idle(8));
        cyc("rstmem_exe", ob_exe(1'b1, 8));
        cyc("rstmem_mem0", ob_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8));
        cyc("rstmem_mem1", ob_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8));
        pulse_reset("rstmem_rst");

        // Illegal opcode 0010111 (AUIPC not supported)
        run = 1'b1;
        set_instr(7'b0010111, 3'b000);
        cyc("badop_dec", ob_idle(0));
        for (int i = 0; i < 4; i++) cyc("badop_trap", ob_stop(1'b0, 1'b1, 0));
        pulse_reset("badop_rst");

        // Illegal load width funct3=011 traps from DECODE with no RAM access
        run = 1'b1;
        set_instr(7'b0000011, 3'b011);
        cyc("badld_dec", ob_idle(0));
        cyc("badld_trap", ob_stop(1'b0, 1'b1, 0));
        cyc("badld_trap_b", ob_stop(1'b0, 1'b1, 0));
        pulse_reset("badld_rst");

        // Illegal store width funct3=011
        run = 1'b1;
        set_instr(7'b0100011, 3'b011);
        cyc("badst_dec", ob_idle(0));
        cyc("badst_trap", ob_stop(1'b0, 1'b1, 0));
        pulse_reset("badst_rst");

        // SH before timeout test, so the count is nonzero when the timeout trap hits
        run = 1'b1;
        set_instr(7'b0100011, 3'b001);
        ramReady = 1'b1;
        cyc("sh_dec", ob_idle(0));
        cyc("sh_exe", ob_exe(1'b1, 0));
        cyc("sh_mem", ob_mem(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0));
        cyc("sh_wb", ob_wb(2'b00, 1'b0, 1'b1, 2'b00, 0));
        ramReady = 1'b0;
        cyc("sh_fetch", ob_idle(1));

        // LW with ramReady stuck low: 15 MEM cycles then TRAP
        set_instr(7'b0000011, 3'b010);
        cyc("tmo_dec", ob_idle(1));
        cyc("tmo_exe", ob_exe(1'b1, 1));
        for (int i = 0; i < 15; i++) cyc("tmo_mem", ob_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1));
        cyc("tmo_trap", ob_stop(1'b0, 1'b1, 1));
        ramReady = 1'b1;
        cyc("tmo_trap_late_ready", ob_stop(1'b0, 1'b1, 1));
        ramReady = 1'b0;
        pulse_reset("tmo_rst");

        // ECALL halts; 20 further cycles with all strobes low
        run = 1'b1;
        set_instr(7'b1110011, 3'b000);
        cyc("ecall_dec", ob_idle(0));
        cyc("ecall_halt", ob_stop(1'b1, 1'b0, 0));
        for (int i = 0; i < 20; i++) cyc("ecall_hold", ob_stop(1'b1, 1'b0, 0));
        pulse_reset("ecall_rst");

        // Let the monitor drain the queue, then confirm nothing is left unchecked
        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
